prefetch_unit: RTL and testbench
================================

# prefetch_unit

Parametrised instruction-fetch front end that replaces the single-PC fetch stage with a PC register plus a DEPTH-entry prefetch queue. It sits between the instruction side of `datapath_cache_if` and the IF/ID pipeline register. It keeps fetching sequentially while decode is stalled, and it flushes and redirects on taken branches, jumps, JAL and JR resolved downstream.

## Interface
Parameters:
- `PC_INIT`, default 32'h0000_0000: reset fetch address; must be word aligned.
- `DEPTH`, default 4: queue entries; power of two, at least 2.

Ports:
- `CLK`  in  1  clock; all state updates on the rising edge.
- `nRST`  in  1  reset, asynchronous and active-low.
- `imemREN`  out  1  instruction read request to the cache.
- `imemaddr`  out  32  fetch address; always equals the internal PC.
- `imemload`  in  32  instruction returned by the cache.
- `ihit`  in  1  `imemload` is valid for `imemaddr` this cycle.
- `redirect`  in  1  control-flow change; flush the queue and load a new PC.
- `redirect_addr`  in  32  new fetch address; bits [1:0] are ignored and forced to 00.
- `halt`  in  1  stop issuing fetches; held level.
- `deq`  in  1  the IF/ID register consumes the head entry this cycle.
- `instr`  out  32  head instruction; 0 when the queue is empty.
- `instr_pc`  out  32  address of the head instruction; 0 when empty.
- `valid`  out  1  queue is non-empty.
- `count`  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.

## Operation
State: `pc`, head pointer, tail pointer, `count`, and DEPTH entries of {instr, pc}.

- `imemREN = !full && !halt && !redirect`, where `full = (count == DEPTH)`.
- Enqueue happens when `imemREN && ihit`:
  - write {imemload, pc} at the tail;
  - tail advances and wraps modulo DEPTH;
  - `pc <= pc + 4`, wrapping modulo 2^32.
- Dequeue happens when `deq && valid`: head advances with wrap. `deq` while empty is ignored and is not an error.
- Simultaneous enqueue and dequeue:
  - both pointers move and `count` is unchanged;
  - with a full queue no enqueue is possible, because `imemREN` is 0; only the dequeue occurs.
- Redirect has the highest priority. On a cycle with `redirect=1`:
  - head, tail and `count` go to 0;
  - `pc <= {redirect_addr[31:2],2'b00}`;
  - any `ihit` and any `deq` in that cycle are discarded.
  - Redirect is honoured while `halt` is asserted.
- Halt:
  - blocks new fetches only;
  - queued entries still drain through `deq`;
  - deasserting `halt` resumes fetch at the current `pc`.
- Reset can be asserted mid-operation:
  - `pc = PC_INIT`; pointers and `count` = 0;
  - `valid=0`, `instr=0`, `instr_pc=0`;
  - `imemREN=1` once `nRST` is high, unless `halt` is set.
- Entry storage is not reset; the outputs are gated to 0 while empty.

## Timing
- Fetch latency: `ihit` in cycle N gives `valid=1` with that instruction in cycle N+1 if the queue was empty.
- Throughput: one instruction per cycle when `ihit` stays high and `deq` stays high.
- Redirect in cycle N:
  - cycle N+1: `imemaddr=redirect_addr`, `valid=0`, `count=0`, `imemREN` re-asserted;
  - the first target instruction is visible no earlier than N+2.
- `imemaddr` changes only on an enqueue edge, a redirect edge or reset, so it is stable for a blocking cache miss.
- `imemREN` is combinational from `count`, `halt` and `redirect`. There is no path from `deq` to `imemREN`.
- `valid`, `instr`, `instr_pc` and `count` come from registered state only.

## Structure
- `cpu_types_pkg`:
  - add `fetch_entry_t` as a packed struct {word_t instr; word_t pc};
  - reuse `word_t`.
- Sub-module `fetch_fifo`:
  - parameters DEPTH and the entry type;
  - ports `wen`, `ren`, `flush`, `wdata`, `rdata`, `count`, `full`, `empty`;
  - asynchronous active-low reset.
- `prefetch_unit` holds only the PC register, the request logic and the redirect/flush priority.

## Test plan
- **Reset.** Sequence: `PC_INIT`=0x200, DEPTH=4, `ihit=1` continuously, `deq=0`. Required:
  - addresses 0x200, 0x204, 0x208 and 0x20C are fetched;
  - `count` reaches 4;
  - then `imemREN=0` and `imemaddr` holds at 0x210.
- **Full with dequeue.** Queue full, `deq=1` for one cycle. Required:
  - `count` goes 4→3;
  - on the next cycle 0x210 is fetched and `count` returns to 4;
  - the head `instr_pc` goes 0x200→0x204.
- **Streaming.** `ihit` and `deq` both held at 1 from empty. Required:
  - after the first cycle, `count` stays at 1;
  - `instr_pc` increments by 4 every cycle.
- **Redirect with hit.** Queue at 3 entries; `redirect=1` with `redirect_addr`=0x1003 in the same cycle as `ihit=1` and `deq=1`. Required:
  - next cycle: `count=0`, `valid=0`, `imemaddr`=0x1000;
  - the discarded hit never appears at the output.
- **Halt.** Assert `halt` with 2 entries queued. Required:
  - `imemREN=0` immediately;
  - both entries drain through `deq`;
  - after `halt` deasserts, fetch resumes at the unchanged `pc`.
- **Asynchronous reset mid-stream.** Pull `nRST` low between clock edges. Required:
  - outputs drop to their reset values without waiting for `CLK`;
  - after release, the first fetch is at `PC_INIT`.
- **Wrap-around.** Run 3×DEPTH enqueues and dequeues. Required:
  - program order is preserved across pointer wrap;
  - a `pc` starting at 0xFFFF_FFFC wraps to 0x0000_0000.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// Shared CPU word and fetch-queue entry types.
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef struct packed {
        word_t instr;
        word_t pc;
    } fetch_entry_t;

    localparam word_t WORD_BYTES = 32'd4;
    localparam word_t WORD_ALIGN_MASK = 32'hFFFF_FFFC;

endpackage

// File: rtl/fetch_fifo.sv
// Circular queue of fetch entries with synchronous flush; entry storage is not reset.
import cpu_types_pkg::*;

module fetch_fifo #(
    parameter int  DEPTH   = 4,
    parameter type entry_t = fetch_entry_t
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   wen,
    input  logic                   ren,
    input  logic                   flush,
    input  entry_t                 wdata,
    output entry_t                 rdata,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    entry_t          r_mem [DEPTH];
    logic [AW-1:0]   r_head;
    logic [AW-1:0]   r_tail;
    logic [CW-1:0]   r_count;
    logic            w_do_wr;
    logic            w_do_rd;

    assign full    = (r_count == CW'(DEPTH));
    assign empty   = (r_count == '0);
    assign w_do_wr = wen && !full && !flush;
    assign w_do_rd = ren && !empty && !flush;
    assign count   = r_count;
    assign rdata   = r_mem[r_head];

    // DEPTH is a power of two, so natural pointer overflow is the wrap
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else if (flush) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_do_wr) r_tail <= r_tail + 1'b1;
            if (w_do_rd) r_head <= r_head + 1'b1;
            if (w_do_wr && !w_do_rd)      r_count <= r_count + 1'b1;
            else if (!w_do_wr && w_do_rd) r_count <= r_count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_wr) r_mem[r_tail] <= wdata;
    end

endmodule

// File: rtl/prefetch_unit.sv
// Fetch front end: PC register, request gating and redirect priority around fetch_fifo.
import cpu_types_pkg::*;

module prefetch_unit #(
    parameter word_t PC_INIT = 32'h0000_0000,
    parameter int    DEPTH   = 4
) (
    input  logic                   CLK,
    input  logic                   nRST,
    output logic                   imemREN,
    output logic [31:0]            imemaddr,
    input  logic [31:0]            imemload,
    input  logic                   ihit,
    input  logic                   redirect,
    input  logic [31:0]            redirect_addr,
    input  logic                   halt,
    input  logic                   deq,
    output logic [31:0]            instr,
    output logic [31:0]            instr_pc,
    output logic                   valid,
    output logic [$clog2(DEPTH):0] count
);

    word_t        r_pc;
    fetch_entry_t w_wdata;
    fetch_entry_t w_rdata;
    logic         w_full;
    logic         w_empty;
    logic         w_enq;
    logic         w_ren;

    assign imemREN  = !w_full && !halt && !redirect;
    assign w_enq    = imemREN && ihit;
    // redirect wins over a same-cycle dequeue; the fifo flush also blocks it
    assign w_ren    = deq && !redirect;
    assign w_wdata  = '{instr: imemload, pc: r_pc};
    assign imemaddr = r_pc;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST)          r_pc <= PC_INIT;
        else if (redirect)  r_pc <= redirect_addr & WORD_ALIGN_MASK;
        else if (w_enq)     r_pc <= r_pc + WORD_BYTES;
    end

    fetch_fifo #(
        .DEPTH   (DEPTH),
        .entry_t (fetch_entry_t)
    ) u_fifo (
        .clk   (CLK),
        .rst_n (nRST),
        .wen   (w_enq),
        .ren   (w_ren),
        .flush (redirect),
        .wdata (w_wdata),
        .rdata (w_rdata),
        .count (count),
        .full  (w_full),
        .empty (w_empty)
    );

    assign valid    = !w_empty;
    assign instr    = w_empty ? '0 : w_rdata.instr;
    assign instr_pc = w_empty ? '0 : w_rdata.pc;

endmodule

// File: tb/tb_prefetch_unit.sv
// Directed vector bench for prefetch_unit with a small queue model for the wrap run.
module tb_prefetch_unit;

    localparam logic [31:0] PC_INIT = 32'h0000_0200;
    localparam int          DEPTH   = 4;

    logic        CLK = 1'b0;
    logic        nRST;
    logic        imemREN;
    logic [31:0] imemaddr;
    logic [31:0] imemload;
    logic        ihit;
    logic        redirect;
    logic [31:0] redirect_addr;
    logic        halt;
    logic        deq;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        valid;
    logic [2:0]  count;

    int n_checks = 0;
    int n_errors = 0;

    always #5 CLK = ~CLK;

    function automatic logic [31:0] cache_word(logic [31:0] a);
        return a ^ 32'hDEAD_0000;
    endfunction

    assign imemload = cache_word(imemaddr);

    prefetch_unit #(.PC_INIT(PC_INIT), .DEPTH(DEPTH)) dut (
        .CLK           (CLK),
        .nRST          (nRST),
        .imemREN       (imemREN),
        .imemaddr      (imemaddr),
        .imemload      (imemload),
        .ihit          (ihit),
        .redirect      (redirect),
        .redirect_addr (redirect_addr),
        .halt          (halt),
        .deq           (deq),
        .instr         (instr),
        .instr_pc      (instr_pc),
        .valid         (valid),
        .count         (count)
    );

    typedef struct {
        logic        ihit;
        logic        deq;
        logic        redir;
        logic [31:0] raddr;
        logic        halt;
        logic [2:0]  e_cnt;
        logic        e_valid;
        logic [31:0] e_ipc;
        logic [31:0] e_addr;
        logic        e_ren;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic add(input logic ih, input logic dq, input logic rd, input logic [31:0] ra,
                       input logic hl, input logic [2:0] c, input logic v,
                       input logic [31:0] ipc, input logic [31:0] addr, input logic ren);
        vec_t t;
        t.ihit = ih; t.deq = dq; t.redir = rd; t.raddr = ra; t.halt = hl;
        t.e_cnt = c; t.e_valid = v; t.e_ipc = ipc; t.e_addr = addr; t.e_ren = ren;
        vecs.push_back(t);
    endtask

    task automatic chk_state(input string tag, input logic [2:0] c, input logic v,
                             input logic [31:0] ipc, input logic [31:0] addr, input logic ren);
        chk({tag, " count"},    {29'd0, count},   {29'd0, c});
        chk({tag, " valid"},    {31'd0, valid},   {31'd0, v});
        chk({tag, " instr_pc"}, instr_pc,         ipc);
        chk({tag, " instr"},    instr,            v ? cache_word(ipc) : 32'd0);
        chk({tag, " imemaddr"}, imemaddr,         addr);
        chk({tag, " imemREN"},  {31'd0, imemREN}, {31'd0, ren});
    endtask

    initial begin
        logic [31:0] mq[$];
        logic [31:0] mpc;
        int          pushes;
        int          pops;
        int          cyc;
        logic        mren;

        nRST = 1'b0; ihit = 1'b0; deq = 1'b0; redirect = 1'b0;
        redirect_addr = '0; halt = 1'b0;

        // fill from reset, then full
        add(1,0,0,0,0, 0,0,32'h0,        32'h200, 1);
        add(1,0,0,0,0, 1,1,32'h200,      32'h204, 1);
        add(1,0,0,0,0, 2,1,32'h200,      32'h208, 1);
        add(1,0,0,0,0, 3,1,32'h200,      32'h20C, 1);
        add(1,0,0,0,0, 4,1,32'h200,      32'h210, 0);
        add(1,0,0,0,0, 4,1,32'h200,      32'h210, 0);
        // single dequeue from full, refill at 0x210
        add(1,1,0,0,0, 4,1,32'h200,      32'h210, 0);
        add(1,0,0,0,0, 3,1,32'h204,      32'h210, 1);
        add(1,1,0,0,0, 4,1,32'h204,      32'h214, 0);
        // redirect with hit and deq at 3 entries
        add(1,1,1,32'h1003,0, 3,1,32'h208, 32'h214, 0);
        add(0,0,0,0,0, 0,0,32'h0,        32'h1000, 1);
        // streaming
        add(1,1,0,0,0, 0,0,32'h0,        32'h1000, 1);
        add(1,1,0,0,0, 1,1,32'h1000,     32'h1004, 1);
        add(1,1,0,0,0, 1,1,32'h1004,     32'h1008, 1);
        add(1,1,0,0,0, 1,1,32'h1008,     32'h100C, 1);
        add(0,0,0,0,0, 1,1,32'h100C,     32'h1010, 1);
        // halt with two entries queued, drain, resume
        add(1,0,0,0,0, 1,1,32'h100C,     32'h1010, 1);
        add(1,0,0,0,1, 2,1,32'h100C,     32'h1014, 0);
        add(1,1,0,0,1, 2,1,32'h100C,     32'h1014, 0);
        add(1,1,0,0,1, 1,1,32'h1010,     32'h1014, 0);
        add(1,1,0,0,1, 0,0,32'h0,        32'h1014, 0);
        add(1,0,0,0,0, 0,0,32'h0,        32'h1014, 1);
        add(0,0,0,0,0, 1,1,32'h1014,     32'h1018, 1);
        // redirect honoured under halt, then pc wrap at 2^32
        add(1,0,1,32'hFFFF_FFFE,1, 1,1,32'h1014, 32'h1018, 0);
        add(1,0,0,0,0, 0,0,32'h0,        32'hFFFF_FFFC, 1);
        add(1,1,0,0,0, 1,1,32'hFFFF_FFFC, 32'h0, 1);
        add(0,0,0,0,0, 1,1,32'h0,        32'h4, 1);

        repeat (2) @(negedge CLK);
        chk_state("reset", 3'd0, 1'b0, 32'h0, PC_INIT, 1'b1);
        nRST = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge CLK);
            ihit = vecs[i].ihit; deq = vecs[i].deq; redirect = vecs[i].redir;
            redirect_addr = vecs[i].raddr; halt = vecs[i].halt;
            #1;
            chk_state($sformatf("vec%0d", i), vecs[i].e_cnt, vecs[i].e_valid,
                      vecs[i].e_ipc, vecs[i].e_addr, vecs[i].e_ren);
        end

        // wrap-around run: model continues from the table's final state
        mq.push_back(32'h0);
        mpc = 32'h4; pushes = 0; pops = 0; cyc = 0;
        while ((pushes < 3*DEPTH || pops < 3*DEPTH) && cyc < 200) begin
            @(negedge CLK);
            ihit = (cyc % 3) != 2; deq = (cyc % 5) != 4; redirect = 1'b0; halt = 1'b0;
            #1;
            mren = (mq.size() < DEPTH);
            chk($sformatf("wrap%0d imemaddr", cyc), imemaddr, mpc);
            chk($sformatf("wrap%0d count", cyc), {29'd0, count}, mq.size());
            if (mq.size() > 0) begin
                chk($sformatf("wrap%0d instr_pc", cyc), instr_pc, mq[0]);
                chk($sformatf("wrap%0d instr", cyc), instr, cache_word(mq[0]));
            end
            if (deq && mq.size() > 0) begin
                void'(mq.pop_front());
                pops++;
            end
            if (mren && ihit) begin
                mq.push_back(mpc);
                mpc += 32'd4;
                pushes++;
            end
            cyc++;
        end
        chk("wrap budget", {31'd0, (cyc < 200)}, 32'd1);

        // asynchronous reset between edges
        @(negedge CLK);
        ihit = 1'b1; deq = 1'b0;
        #3 nRST = 1'b0;
        #1;
        chk_state("async_rst", 3'd0, 1'b0, 32'h0, PC_INIT, 1'b1);
        @(negedge CLK);
        nRST = 1'b1;
        #1;
        chk_state("rst_release", 3'd0, 1'b0, 32'h0, PC_INIT, 1'b1);
        @(posedge CLK);
        #1;
        chk_state("first_fetch", 3'd1, 1'b1, PC_INIT, PC_INIT + 32'd4, 1'b1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
